minhash_sketch_unit: RTL

- Consumer end of the `murmur_4bytes` hasher.
- Accepts a stream of 32-bit k-mers over valid/ready.
- Hashes each k-mer under NUM_SEEDS seeds, one seed per cycle, through a single hasher instance, and keeps the running minimum signature per seed.
- On the last k-mer of a frame, drains the NUM_SEEDS minima as the MinHash sketch over a valid/ready output, then re-arms for the next frame.

---
 rtl/minhash_pkg.sv | 24 ++
 rtl/murmur_4bytes.sv | 28 ++
 rtl/minhash_sketch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/minhash_pkg.sv
// Shared types, seed constants and seed derivation for the MinHash sketch unit.
package minhash_pkg;

  localparam int unsigned HASHER_DATA_BITS = 32;

  localparam logic [HASHER_DATA_BITS-1:0] SEED_BASE = 32'hac718add;
  localparam logic [HASHER_DATA_BITS-1:0] SEED_STEP = 32'h9e3779b9;

  typedef enum logic [1:0] {
    IDLE,
    HASH,
    DRAIN
  } state_t;

  // seed(i) = base + i*step, wrapping at the data width.
  function automatic logic [HASHER_DATA_BITS-1:0] seed_of(
    input int unsigned                  idx,
    input logic [HASHER_DATA_BITS-1:0]  base = SEED_BASE,
    input logic [HASHER_DATA_BITS-1:0]  step = SEED_STEP
  );
    return base + HASHER_DATA_BITS'(idx) * step;
  endfunction

endpackage

// File: rtl/murmur_4bytes.sv
// Combinational MurmurHash3 (x86_32) of a single 4-byte key under a 32-bit seed.
module murmur_4bytes (
  input  logic [31:0] seed,
  input  logic [31:0] data,
  output logic [31:0] hash
);

  logic [31:0] k0, k1, k2;
  logic [31:0] h0, h1, h2;
  logic [31:0] f0, f1, f2, f3, f4;

  // Key mix, one body round, length fold and final avalanche.
  always_comb begin
    k0   = data * 32'hcc9e2d51;
    k1   = {k0[16:0], k0[31:17]};
    k2   = k1 * 32'h1b873593;
    h0   = seed ^ k2;
    h1   = {h0[18:0], h0[31:19]};
    h2   = h1 * 32'd5 + 32'he6546b64;
    f0   = h2 ^ 32'd4;
    f1   = f0 ^ (f0 >> 16);
    f2   = f1 * 32'h85ebca6b;
    f3   = f2 ^ (f2 >> 13);
    f4   = f3 * 32'hc2b2ae35;
    hash = f4 ^ (f4 >> 16);
  end

endmodule

// File: rtl/minhash_sketch_unit.sv
// MinHash sketch: hashes each k-mer under NUM_SEEDS seeds (one per cycle) and
// keeps per-seed minima; drains the sketch after the last k-mer of a frame.
module minhash_sketch_unit
  import minhash_pkg::*;
#(
  parameter int unsigned                   HASHER_DATA_BITS = minhash_pkg::HASHER_DATA_BITS,
  parameter int unsigned                   NUM_SEEDS        = 8,
  parameter logic [HASHER_DATA_BITS-1:0]   SEED_BASE        = minhash_pkg::SEED_BASE,
  parameter logic [HASHER_DATA_BITS-1:0]   SEED_STEP        = minhash_pkg::SEED_STEP,
  localparam int unsigned                  IDX_W            = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         kmer_valid,
  output logic                         kmer_ready,
  input  logic [HASHER_DATA_BITS-1:0]  kmer_data,
  input  logic                         kmer_last,
  output logic                         sk_valid,
  input  logic                         sk_ready,
  output logic [HASHER_DATA_BITS-1:0]  sk_data,
  output logic [IDX_W-1:0]             sk_idx,
  output logic                         sk_last,
  output logic                         busy
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SEEDS - 1);

  state_t                        state_q, state_nxt;
  logic [IDX_W-1:0]              idx_q;
  logic [HASHER_DATA_BITS-1:0]   kmer_q;
  logic                          last_q;
  logic [HASHER_DATA_BITS-1:0]   min_q [NUM_SEEDS];
  logic [HASHER_DATA_BITS-1:0]   seed;
  logic [HASHER_DATA_BITS-1:0]   signature;
  logic                          idx_at_last;
  logic                          kmer_fire;
  logic                          sk_fire;

  assign idx_at_last = (idx_q == IDX_LAST);
  assign seed        = seed_of(int'(idx_q), SEED_BASE, SEED_STEP);
  assign kmer_fire   = kmer_valid && (state_q == IDLE);
  assign sk_fire     = sk_ready && (state_q == DRAIN);

  murmur_4bytes u_hasher (
    .seed (seed),
    .data (kmer_q),
    .hash (signature)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_nxt  = state_q;
    kmer_ready = 1'b0;
    sk_valid   = 1'b0;
    sk_data    = '0;
    sk_idx     = '0;
    sk_last    = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE: begin
        kmer_ready = 1'b1;
        busy       = 1'b0;
        if (kmer_valid) state_nxt = HASH;
      end
      HASH: begin
        if (idx_at_last) state_nxt = last_q ? DRAIN : IDLE;
      end
      DRAIN: begin
        sk_valid = 1'b1;
        sk_data  = min_q[idx_q];
        sk_idx   = idx_q;
        sk_last  = idx_at_last;
        if (sk_ready && idx_at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: k-mer capture, seed index, running minima and re-arm after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      kmer_q <= '0;
      last_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SEEDS; i++) min_q[i] <= '1;
    end else begin
      if (kmer_fire) begin
        kmer_q <= kmer_data;
        last_q <= kmer_last;
        idx_q  <= '0;
      end
      if (state_q == HASH) begin
        if (signature < min_q[idx_q]) min_q[idx_q] <= signature;
        idx_q <= idx_at_last ? '0 : idx_q + 1'b1;
      end
      if (sk_fire) begin
        if (idx_at_last) begin
          idx_q <= '0;
          for (int unsigned i = 0; i < NUM_SEEDS; i++) min_q[i] <= '1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule
